// File: rtl/opl3_axi4lite_mc.sv
// opl3_axi4lite_mc: AXI4-Lite register-write bridge feeding NUM_CORES OPL3 cores.
// Define OPL3_AXI_SHADOW_EN to build the per-core register shadow readback RAM.
module opl3_axi4lite_mc #(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_GAP     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_awvalid_i,
  input  logic [31:0]          cfg_awaddr_i,
  output logic                 cfg_awready_o,
  input  logic                 cfg_wvalid_i,
  input  logic [31:0]          cfg_wdata_i,
  input  logic [3:0]           cfg_wstrb_i,
  output logic                 cfg_wready_o,
  output logic                 cfg_bvalid_o,
  output logic [1:0]           cfg_bresp_o,
  input  logic                 cfg_bready_i,
  input  logic                 cfg_arvalid_i,
  input  logic [31:0]          cfg_araddr_i,
  output logic                 cfg_arready_o,
  output logic                 cfg_rvalid_o,
  output logic [31:0]          cfg_rdata_o,
  output logic [1:0]           cfg_rresp_o,
  input  logic                 cfg_rready_i,
  output logic [NUM_CORES-1:0] opl_we_o,
  output logic [8:0]           opl_adr_o,
  output logic [7:0]           opl_data_o
);
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = CORE_W + 17;
  localparam logic [2:0] NC = 3'(NUM_CORES);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [7:0] GAP_LD = 8'(WR_GAP - 1);

  logic aw_held, w_held, w_strb0;
  logic [31:0] aw_addr;
  logic [7:0] w_data;
  logic bvalid, rvalid, err_sticky;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [7:0] gap;
  logic full, empty, pop, commit, aw_bad, push, ar_acc, st_rd;
  logic [1:0] aw_cidx;
  logic [EW-1:0] entry, head;
  logic [CORE_W-1:0] head_core;
  logic [NUM_CORES-1:0] head_oh;
  logic [31:0] rd_word;
  logic [1:0] rd_resp;
  logic unused_bits;

`ifdef OPL3_AXI_SHADOW_EN
  logic [7:0] shadow [NUM_CORES*512];
`endif

  assign cfg_awready_o = ~aw_held;
  assign cfg_wready_o  = ~w_held;
  assign cfg_arready_o = ~rvalid;
  assign cfg_bvalid_o  = bvalid;
  assign cfg_rvalid_o  = rvalid;

  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
  assign pop    = ~empty & (gap == 8'd0);
  // The full two-bit core field is decoded so unused core bits fault too.
  assign aw_cidx = aw_addr[12:11];
  assign aw_bad = ({1'b0, aw_cidx} >= NC) | (aw_addr[31:13] != 19'd0);
  assign commit = aw_held & w_held & ~bvalid & (~full | pop);
  assign push   = commit & ~aw_bad & w_strb0;
  assign entry  = {aw_cidx[CORE_W-1:0], aw_addr[10:2], w_data};
  assign head      = mem[rd_ptr];
  assign head_core = head[EW-1:17];
  assign ar_acc = cfg_arvalid_i & ~rvalid;
  assign st_rd  = ar_acc & ~cfg_araddr_i[13];
  assign unused_bits = ^{cfg_wdata_i[31:8], cfg_wstrb_i[3:1],
                         cfg_araddr_i, aw_addr[1:0]};

  // One-hot strobe for the core at the queue head
  always_comb begin
    head_oh = '0;
    head_oh[head_core] = 1'b1;
  end

  // Read data mux: status word or shadow byte
  always_comb begin
    rd_word = '0;
    rd_resp = 2'b00;
    if (!cfg_araddr_i[13])
      rd_word = {15'd0, err_sticky, 6'd0, empty, full,
                 2'd0, 6'(level)};
`ifdef OPL3_AXI_SHADOW_EN
    else if ({1'b0, cfg_araddr_i[12:11]} >= NC)
      rd_resp = 2'b10;
    else
      rd_word = {24'd0, shadow[{cfg_araddr_i[11+CORE_W-1:11],
                                cfg_araddr_i[10:2]}]};
`endif
  end

  // Independent AW and W single-entry holds
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb0 <= 1'b0;
    end else begin
      if (cfg_awvalid_i && !aw_held) begin
        aw_held <= 1'b1;
        aw_addr <= cfg_awaddr_i;
      end else if (commit) begin
        aw_held <= 1'b0;
      end
      if (cfg_wvalid_i && !w_held) begin
        w_held  <= 1'b1;
        w_data  <= cfg_wdata_i[7:0];
        w_strb0 <= cfg_wstrb_i[0];
      end else if (commit) begin
        w_held <= 1'b0;
      end
    end
  end

  // Write response channel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bvalid      <= 1'b0;
      cfg_bresp_o <= 2'b00;
    end else if (commit) begin
      bvalid      <= 1'b1;
      cfg_bresp_o <= aw_bad ? 2'b10 : 2'b00;
    end else if (bvalid && cfg_bready_i) begin
      bvalid <= 1'b0;
    end
  end

  // Queue pointers and fill level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Queue storage; stale entries are harmless after reset
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Paced issue of queued writes to the cores
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap        <= '0;
      opl_we_o   <= '0;
      opl_adr_o  <= '0;
      opl_data_o <= '0;
    end else begin
      opl_we_o <= pop ? head_oh : '0;
      if (pop) begin
        gap        <= GAP_LD;
        opl_adr_o  <= head[16:8];
        opl_data_o <= head[7:0];
      end else if (gap != 8'd0) begin
        gap <= gap - 8'd1;
      end
    end
  end

  // Read channel and sticky decode-error flag (set beats clear)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid      <= 1'b0;
      cfg_rdata_o <= '0;
      cfg_rresp_o <= 2'b00;
      err_sticky  <= 1'b0;
    end else begin
      if (ar_acc) begin
        rvalid      <= 1'b1;
        cfg_rdata_o <= rd_word;
        cfg_rresp_o <= rd_resp;
      end else if (rvalid && cfg_rready_i) begin
        rvalid <= 1'b0;
      end
      if (commit && aw_bad) err_sticky <= 1'b1;
      else if (st_rd)       err_sticky <= 1'b0;
    end
  end

`ifdef OPL3_AXI_SHADOW_EN
  // Shadow copy of every accepted register write
  always_ff @(posedge clk_i) begin
    if (push)
      shadow[{aw_cidx[CORE_W-1:0], aw_addr[10:2]}] <= w_data;
  end
`endif

endmodule

// File: tb/tb_opl3_axi4lite_mc.sv
// tb_opl3_axi4lite_mc: directed bench for opl3_axi4lite_mc (default params).
// Shadow expectations follow OPL3_AXI_SHADOW_EN.
module tb_opl3_axi4lite_mc;
  logic clk_i = 0, rst_ni = 0;
  logic cfg_awvalid_i = 0, cfg_wvalid_i = 0, cfg_arvalid_i = 0;
  logic [31:0] cfg_awaddr_i = 0, cfg_wdata_i = 0, cfg_araddr_i = 0;
  logic [3:0] cfg_wstrb_i = 0;
  logic cfg_bready_i = 1, cfg_rready_i = 1;
  logic cfg_awready_o, cfg_wready_o, cfg_bvalid_o, cfg_arready_o, cfg_rvalid_o;
  logic [1:0] cfg_bresp_o, cfg_rresp_o;
  logic [31:0] cfg_rdata_o;
  logic [1:0] opl_we_o;
  logic [8:0] opl_adr_o;
  logic [7:0] opl_data_o;

  int compared = 0, mismatched = 0, cyc = 0;
  int ev_cyc[$];
  logic [1:0] ev_we[$];
  logic [8:0] ev_adr[$];
  logic [7:0] ev_dat[$];
  logic [1:0] b_q[$];

  opl3_axi4lite_mc dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_awvalid_i(cfg_awvalid_i), .cfg_awaddr_i(cfg_awaddr_i),
    .cfg_awready_o(cfg_awready_o), .cfg_wvalid_i(cfg_wvalid_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_wstrb_i(cfg_wstrb_i),
    .cfg_wready_o(cfg_wready_o), .cfg_bvalid_o(cfg_bvalid_o),
    .cfg_bresp_o(cfg_bresp_o), .cfg_bready_i(cfg_bready_i),
    .cfg_arvalid_i(cfg_arvalid_i), .cfg_araddr_i(cfg_araddr_i),
    .cfg_arready_o(cfg_arready_o), .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o), .cfg_rresp_o(cfg_rresp_o),
    .cfg_rready_i(cfg_rready_i), .opl_we_o(opl_we_o),
    .opl_adr_o(opl_adr_o), .opl_data_o(opl_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle counter
  always @(posedge clk_i) cyc++;

  // Record core strobes and write responses
  always @(negedge clk_i) begin
    if (opl_we_o != 2'b00) begin
      ev_cyc.push_back(cyc);
      ev_we.push_back(opl_we_o);
      ev_adr.push_back(opl_adr_o);
      ev_dat.push_back(opl_data_o);
    end
    if (cfg_bvalid_o && cfg_bready_i) b_q.push_back(cfg_bresp_o);
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    ev_cyc.delete(); ev_we.delete(); ev_adr.delete();
    ev_dat.delete(); b_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int waited);
    bit ad, wd;
    int n;
    ad = 0; wd = 0; n = 0;
    cfg_awaddr_i = a; cfg_wdata_i = d; cfg_wstrb_i = s;
    cfg_awvalid_i = 1; cfg_wvalid_i = 1;
    while (!(ad && wd) && n < 200) begin
      @(negedge clk_i);
      if (cfg_awvalid_i && cfg_awready_o) ad = 1;
      if (cfg_wvalid_i && cfg_wready_o) wd = 1;
      @(posedge clk_i); #1;
      if (ad) cfg_awvalid_i = 0;
      if (wd) cfg_wvalid_i = 0;
      n++;
    end
    waited = n;
    compared++;
    if (!(ad && wd)) begin
      mismatched++;
      $display("FAIL write_accept a=%h: got aw=%0d w=%0d want 1 1", a, ad, wd);
      cfg_awvalid_i = 0; cfg_wvalid_i = 0;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r);
    bit acc, got;
    int n;
    acc = 0; got = 0; n = 0; d = 'x; r = 'x;
    cfg_araddr_i = a; cfg_arvalid_i = 1;
    while (!acc && n < 200) begin
      @(negedge clk_i);
      if (cfg_arready_o) acc = 1;
      @(posedge clk_i); #1;
      if (acc) cfg_arvalid_i = 0;
      n++;
    end
    cfg_arvalid_i = 0;
    n = 0;
    while (acc && !got && n < 50) begin
      @(negedge clk_i);
      if (cfg_rvalid_o) begin
        got = 1; d = cfg_rdata_o; r = cfg_rresp_o;
      end
      n++;
    end
    if (got) begin @(posedge clk_i); #1; end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL read_timeout a=%h: got no rvalid want rvalid", a);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    @(negedge clk_i);
    compared++;
    if ({cfg_awready_o, cfg_wready_o, cfg_arready_o, cfg_bvalid_o,
         cfg_rvalid_o} !== 5'b11100) begin
      mismatched++;
      $display("FAIL reset_handshake: got %b want 11100",
               {cfg_awready_o, cfg_wready_o, cfg_arready_o,
                cfg_bvalid_o, cfg_rvalid_o});
    end
    compared++;
    if ({opl_we_o, opl_adr_o, opl_data_o} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_core_out: got %h want 0",
               {opl_we_o, opl_adr_o, opl_data_o});
    end
    compared++;
    if ({cfg_rdata_o, cfg_rresp_o, cfg_bresp_o} !== 36'd0) begin
      mismatched++;
      $display("FAIL reset_data: got %h want 0",
               {cfg_rdata_o, cfg_rresp_o, cfg_bresp_o});
    end
    rst_ni = 1;
    idle(2);
    axi_read(32'h0, d, r);
    compared++;
    if ({d, r} !== {32'h0000_0200, 2'b00}) begin
      mismatched++;
      $display("FAIL reset_status: got %h/%b want 00000200/00", d, r);
    end
  endtask

  task automatic test_single_write();
    int w;
    clear_mon();
    axi_write(32'h2C0, 32'h25, 4'b0001, w);
    idle(40);
    compared++;
    if (b_q.size() != 1 || b_q[0] !== 2'b00) begin
      mismatched++;
      $display("FAIL single_bresp: got n=%0d want 1 OKAY", b_q.size());
    end
    compared++;
    if (ev_cyc.size() != 1) begin
      mismatched++;
      $display("FAIL single_pulses: got %0d want 1", ev_cyc.size());
    end else if ({ev_we[0], ev_adr[0], ev_dat[0]} !== {2'b01, 9'h0B0, 8'h25}) begin
      mismatched++;
      $display("FAIL single_strobe: got we=%b adr=%h d=%h want 01 0b0 25",
               ev_we[0], ev_adr[0], ev_dat[0]);
    end
    clear_mon();
    axi_write(32'hC14, 32'h3C, 4'b0001, w);
    idle(40);
    compared++;
    if (ev_cyc.size() != 1) begin
      mismatched++;
      $display("FAIL core1_pulses: got %0d want 1", ev_cyc.size());
    end else if ({ev_we[0], ev_adr[0], ev_dat[0]} !== {2'b10, 9'h105, 8'h3C}) begin
      mismatched++;
      $display("FAIL core1_strobe: got we=%b adr=%h d=%h want 10 105 3c",
               ev_we[0], ev_adr[0], ev_dat[0]);
    end
  endtask

  task automatic test_shadow();
    logic [31:0] d, exp_d; logic [1:0] r, exp_r;
    axi_read(32'h2C14, d, r);
`ifdef OPL3_AXI_SHADOW_EN
    exp_d = 32'h3C;
`else
    exp_d = 32'h0;
`endif
    compared++;
    if ({d, r} !== {exp_d, 2'b00}) begin
      mismatched++;
      $display("FAIL shadow_read: got %h/%b want %h/00", d, r, exp_d);
    end
    axi_read(32'h3814, d, r);
`ifdef OPL3_AXI_SHADOW_EN
    exp_r = 2'b10;
`else
    exp_r = 2'b00;
`endif
    compared++;
    if (r !== exp_r || (exp_r == 2'b00 && d !== 32'h0)) begin
      mismatched++;
      $display("FAIL shadow_badcore: got %h/%b want resp %b", d, r, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [8:0] adrs [3];
    logic [7:0] dats [3];
    adrs = '{9'h001, 9'h002, 9'h003};
    dats = '{8'h11, 8'h22, 8'h33};
    clear_mon();
    for (int k = 0; k < 3; k++)
      axi_write(32'(adrs[k]) << 2, 32'(dats[k]), 4'b0001, w);
    idle(140);
    compared++;
    if (ev_cyc.size() != 3) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d want 3", ev_cyc.size());
    end else begin
      compared++;
      if (ev_cyc[1] - ev_cyc[0] != 32 || ev_cyc[2] - ev_cyc[1] != 32) begin
        mismatched++;
        $display("FAIL b2b_spacing: got %0d,%0d want 32,32",
                 ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]);
      end
      for (int k = 0; k < 3; k++) begin
        compared++;
        if ({ev_we[k], ev_adr[k], ev_dat[k]} !== {2'b01, adrs[k], dats[k]}) begin
          mismatched++;
          $display("FAIL b2b_order[%0d]: got %b %h %h want 01 %h %h", k,
                   ev_we[k], ev_adr[k], ev_dat[k], adrs[k], dats[k]);
        end
      end
    end
  endtask

  task automatic test_slverr();
    int w;
    logic [31:0] d; logic [1:0] r;
    clear_mon();
    axi_write(32'h1000, 32'h55, 4'b0001, w);
    axi_write(32'h4000, 32'h66, 4'b0001, w);
    idle(40);
    compared++;
    if (b_q.size() != 2 || b_q[0] !== 2'b10 || b_q[1] !== 2'b10) begin
      mismatched++;
      $display("FAIL slverr_bresp: got n=%0d want 2 SLVERR", b_q.size());
    end
    compared++;
    if (ev_cyc.size() != 0) begin
      mismatched++;
      $display("FAIL slverr_no_strobe: got %0d want 0", ev_cyc.size());
    end
    axi_read(32'h0, d, r);
    compared++;
    if (d !== 32'h0001_0200) begin
      mismatched++;
      $display("FAIL slverr_sticky: got %h want 00010200", d);
    end
    axi_read(32'h0, d, r);
    compared++;
    if (d !== 32'h0000_0200) begin
      mismatched++;
      $display("FAIL slverr_cleared: got %h want 00000200", d);
    end
  endtask

  task automatic test_w_first();
    int w;
    clear_mon();
    cfg_wdata_i = 32'h5A; cfg_wstrb_i = 4'b0001; cfg_wvalid_i = 1;
    @(posedge clk_i); #1;
    cfg_wvalid_i = 0;
    idle(2);
    @(negedge clk_i);
    compared++;
    if ({cfg_wready_o, cfg_awready_o, cfg_bvalid_o} !== 3'b010 || b_q.size() != 0) begin
      mismatched++;
      $display("FAIL wfirst_hold: got wr=%b awr=%b bv=%b n=%0d want 0 1 0 0",
               cfg_wready_o, cfg_awready_o, cfg_bvalid_o, b_q.size());
    end
    @(posedge clk_i); #1;
    cfg_awaddr_i = 32'h040; cfg_awvalid_i = 1;
    @(posedge clk_i); #1;
    cfg_awvalid_i = 0;
    idle(40);
    compared++;
    if (b_q.size() != 1 || b_q[0] !== 2'b00) begin
      mismatched++;
      $display("FAIL wfirst_bresp: got n=%0d want 1 OKAY", b_q.size());
    end
    compared++;
    if (ev_cyc.size() != 1) begin
      mismatched++;
      $display("FAIL wfirst_pulses: got %0d want 1", ev_cyc.size());
    end else if ({ev_we[0], ev_adr[0], ev_dat[0]} !== {2'b01, 9'h010, 8'h5A}) begin
      mismatched++;
      $display("FAIL wfirst_strobe: got %b %h %h want 01 010 5a",
               ev_we[0], ev_adr[0], ev_dat[0]);
    end
    clear_mon();
    axi_write(32'h044, 32'h77, 4'b0000, w);
    idle(40);
    compared++;
    if (b_q.size() != 1 || b_q[0] !== 2'b00 || ev_cyc.size() != 0) begin
      mismatched++;
      $display("FAIL nostrb: got b=%0d pulses=%0d want 1 OKAY 0",
               b_q.size(), ev_cyc.size());
    end
  endtask

  task automatic test_fifo_full();
    int w, maxw, maxl, badb, bado, bads;
    bit done, seen_full;
    logic [31:0] d; logic [1:0] r;
    maxw = 0; maxl = 0; done = 0; seen_full = 0;
    clear_mon();
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          axi_write(32'(9'h020 + 9'(k)) << 2, 32'(8'h80 + 8'(k)), 4'b0001, w);
          if (w > maxw) maxw = w;
        end
        done = 1;
      end
      begin
        while (!done) begin
          axi_read(32'h0, d, r);
          if (int'(d[5:0]) > maxl) maxl = int'(d[5:0]);
          if (d[8]) seen_full = 1;
        end
      end
    join
    idle(700);
    compared++;
    if (maxl != 16 || !seen_full) begin
      mismatched++;
      $display("FAIL full_level: got max=%0d full=%0d want 16 1", maxl, seen_full);
    end
    compared++;
    if (maxw <= 8) begin
      mismatched++;
      $display("FAIL full_stall: got max wait %0d want >8", maxw);
    end
    badb = 0;
    foreach (b_q[k]) if (b_q[k] !== 2'b00) badb++;
    compared++;
    if (b_q.size() != 20 || badb != 0) begin
      mismatched++;
      $display("FAIL full_bresp: got n=%0d bad=%0d want 20 0", b_q.size(), badb);
    end
    bado = 0; bads = 0;
    foreach (ev_cyc[k]) begin
      if ({ev_we[k], ev_adr[k], ev_dat[k]} !==
          {2'b01, 9'h020 + 9'(k), 8'h80 + 8'(k)}) bado++;
      if (k > 0 && ev_cyc[k] - ev_cyc[k-1] != 32) bads++;
    end
    compared++;
    if (ev_cyc.size() != 20 || bado != 0 || bads != 0) begin
      mismatched++;
      $display("FAIL full_drain: got n=%0d order_err=%0d gap_err=%0d want 20 0 0",
               ev_cyc.size(), bado, bads);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [31:0] d; logic [1:0] r;
    axi_write(32'h4000, 32'h01, 4'b0001, w);
    for (int k = 0; k < 4; k++)
      axi_write(32'(9'h040 + 9'(k)) << 2, 32'h90 + 32'(k), 4'b0001, w);
    rst_ni = 0;
    @(negedge clk_i);
    compared++;
    if ({cfg_awready_o, cfg_wready_o, cfg_arready_o, cfg_bvalid_o,
         cfg_rvalid_o, opl_we_o} !== 7'b1110000) begin
      mismatched++;
      $display("FAIL midreset_outs: got %b want 1110000",
               {cfg_awready_o, cfg_wready_o, cfg_arready_o, cfg_bvalid_o,
                cfg_rvalid_o, opl_we_o});
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    clear_mon();
    idle(120);
    compared++;
    if (ev_cyc.size() != 0 || b_q.size() != 0) begin
      mismatched++;
      $display("FAIL midreset_discard: got pulses=%0d b=%0d want 0 0",
               ev_cyc.size(), b_q.size());
    end
    axi_read(32'h0, d, r);
    compared++;
    if (d !== 32'h0000_0200) begin
      mismatched++;
      $display("FAIL midreset_status: got %h want 00000200", d);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_shadow();
    test_back_to_back();
    test_slverr();
    test_w_first();
    test_fifo_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule

// File: doc/opl3_axi4lite_mc.md
OPL3_AXI4LITE_MC -- requirements
Module: opl3_axi4lite_mc

Interface
REQ-001 NUM_CORES, 2, number of OPL3 cores addressed (1..4); CORE_W = max(1, clog2(NUM_CORES)).
REQ-002 FIFO_DEPTH, 16, register-write queue entries (power of 2, 4..32).
REQ-003 WR_GAP, 32, minimum clk_i cycles between issued core writes (1..255).
REQ-004 The ports SHALL be, as name  direction  width  meaning:
clk_i  in  1  single clock; all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
cfg_awvalid_i  in  1  write address valid
cfg_awaddr_i  in  32  write address
cfg_awready_o  out  1  write address ready
cfg_wvalid_i  in  1  write data valid
cfg_wdata_i  in  32  write data; [7:0] is the OPL3 register value
cfg_wstrb_i  in  4  byte strobes; only [0] is used
cfg_wready_o  out  1  write data ready
cfg_bvalid_o  out  1  write response valid
cfg_bresp_o  out  2  00 OKAY, 10 SLVERR
cfg_bready_i  in  1  write response ready
cfg_arvalid_i  in  1  read address valid
cfg_araddr_i  in  32  read address
cfg_arready_o  out  1  read address ready
cfg_rvalid_o  out  1  read data valid
cfg_rdata_o  out  32  read data
cfg_rresp_o  out  2  read response
cfg_rready_i  in  1  read data ready
opl_we_o  out  NUM_CORES  one-hot single-cycle register write strobe per core
opl_adr_o  out  9  OPL3 register index
opl_data_o  out  8  OPL3 register data

Function
REQ-005 AW and W SHALL be captured independently into single-entry holds, with awready = ~aw_held and wready = ~w_held, in any arrival order.
REQ-006 Commit SHALL occur in the cycle both holds are full, bvalid is low, and the FIFO is not full; a full FIFO with a simultaneous pop counts as not full. On commit, bvalid SHALL rise the next cycle and both holds SHALL clear.
REQ-007 Decode: core = awaddr[11+CORE_W-1:11], reg = awaddr[10:2]; core >= NUM_CORES or awaddr[31:13] != 0 SHALL give SLVERR with no enqueue and SHALL set err_sticky.
REQ-008 wstrb[0] = 0 SHALL give OKAY with no enqueue.
REQ-009 A valid commit SHALL push {core, reg, wdata[7:0]}; a full FIFO SHALL stall the commit, which keeps awready/wready low (no drop).
REQ-010 Issue: when the FIFO is non-empty and the gap counter is 0, pop and drive opl_we_o[core] = 1 for exactly one cycle, with opl_adr_o/opl_data_o valid that cycle; the counter SHALL load WR_GAP-1 and decrement to 0. WR_GAP = 1 gives back-to-back writes.
REQ-011 bvalid SHALL clear on bready; arready = ~rvalid; rvalid SHALL assert one cycle after AR accept and clear on rready.
REQ-012 Reads with araddr[13] = 0 SHALL return status: [5:0] FIFO level, [8] full, [9] empty, [16] err_sticky, with OKAY. Reading status SHALL clear err_sticky; a same-cycle set SHALL win.
REQ-013 Read and write channels SHALL operate concurrently; no ordering between them.

Reset
REQ-014 When rst_ni is low: holds, FIFO, gap counter and err_sticky cleared; all valid/ready/we outputs 0 except awready/wready/arready = 1; rdata, adr, data, resp = 0. Reset mid-transfer SHALL discard pending entries.

Configuration
REQ-015 With OPL3_AXI_SHADOW_EN defined, a NUM_CORES x 512 x 8 shadow RAM SHALL update on each valid commit. Reads with araddr[13] = 1 SHALL return shadow[araddr[11+CORE_W-1:11]][araddr[10:2]] in rdata[7:0], one cycle latency; an invalid core returns SLVERR. Shadow contents are not reset.
REQ-016 Without OPL3_AXI_SHADOW_EN, reads with araddr[13] = 1 SHALL return 0 with OKAY, and no RAM is built.

Verification
REQ-017 awaddr 0x2C0, wdata 0x25 -> bresp OKAY; opl_we_o = 01 for one cycle with adr 0x0B0, data 0x25.
REQ-018 Three back-to-back writes, WR_GAP = 32 -> opl_we_o pulses exactly 32 cycles apart, in order.
REQ-019 NUM_CORES = 2, awaddr 0x1000 -> SLVERR, no opl_we_o; status read gives bit16 = 1, the next read gives 0.
REQ-020 17 writes with the FIFO full -> 17th AW/W held not ready until the first pop, then OKAY; level never exceeds 16.
REQ-021 W three cycles before AW -> one commit with the correct data; wstrb = 0 -> OKAY, no strobe.
REQ-022 With macro: core 1 reg 0x105 = 0x3C, then read 0x2C14 -> rdata 0x3C; without macro -> 0.
